system_led_sequencer: RTL and testbench
=======================================

Name: system_led_sequencer

Overview:
Avalon-MM controller that drives the 8-bit LED PIO through the PIO's s1 slave port. Software loads a table of LED patterns and a step period over a slave port. The block then autonomously writes the patterns to the PIO in order, looping or one-shot. It sits between the Nios bus and the LED PIO, so the CPU does not have to bit-bang the LEDs.

Parameters:
NUM_PATTERNS, 8, depth of the pattern table (power of 2, 2..16)
DATA_W, 8, LED pattern width; must equal the PIO out_port width
PERIOD_W, 24, width of the step-period counter

Ports:
clk  in  1  system clock; the only clock
reset_n  in  1  asynchronous, active-low reset
address  in  4  slave register address (word)
chipselect  in  1  slave select
write_n  in  1  slave write strobe, active-low
writedata  in  32  slave write data
readdata  out  32  slave read data; combinational, zero wait states
m_address  out  2  master address to the PIO; constant 0
m_chipselect  out  1  master select
m_write_n  out  1  master write strobe, active-low
m_writedata  out  32  master data: zero-extended pattern
m_waitrequest  in  1  master stall; tie to 0 for the PIO

Behaviour:
- Register map (word address):
  - 0 CTRL, rw: bit0 EN, bit1 ONESHOT, bits[7:4] LAST (last table index).
  - 1 PERIOD, rw: [PERIOD_W-1:0].
  - 2 STATUS, ro: bit0 BUSY, bits[7:4] IDX, bit8 DONE (sticky; write 1 to clear).
  - 8..8+NUM_PATTERNS-1: pattern table, rw [DATA_W-1:0].
  - All other addresses read 0 and ignore writes.
- Slave write occurs when chipselect && !write_n; register updates on the next clk edge.
- Reset values:
  - All registers, IDX, DONE and the counter are 0.
  - m_chipselect=0, m_write_n=1, m_writedata=0, state IDLE.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE -> ISSUE when EN=1. IDX=0 on entry.
  - ISSUE: drive m_chipselect=1, m_write_n=0, m_writedata=table[IDX]. Hold these while m_waitrequest=1. On the first cycle with m_waitrequest=0 the write is accepted; go to HOLD and load the counter with PERIOD (0 treated as 1).
  - HOLD: decrement the counter each cycle. On reaching 1:
    - If IDX==LAST and ONESHOT: set DONE, clear EN, go to IDLE.
    - If IDX==LAST and not ONESHOT: set DONE, IDX=0, go to ISSUE.
    - Otherwise: IDX+1, go to ISSUE.
- Timing: each step lasts exactly max(PERIOD,1)+1 clocks from one accepted master write to the next, with no waitrequest.
- LAST greater than NUM_PATTERNS-1 is clamped to NUM_PATTERNS-1.
- BUSY = (state != IDLE).
- EN cleared by software:
  - In HOLD: go to IDLE next cycle.
  - In ISSUE: complete the pending write (Avalon rule: no abort mid-transfer), then go to IDLE.
  - The LEDs keep their last value.
- Write to PERIOD or a table entry while running: takes effect at the next counter load or the next ISSUE of that index. No glitch on the current step.
- Software write-1-to-clear of DONE in the same cycle the hardware sets DONE: the set wins.
- Reset asserted mid-transfer: master outputs go idle immediately (asynchronous). The PIO is reset by the same reset_n.

Optional Feature:
LED_SEQ_IRQ_EN
- Defined: adds output port irq (1 bit), registered, equal to DONE & CTRL bit2 (IE). IE is rw and resets to 0.
- Undefined: no irq port, and CTRL bit2 reads 0 and is not stored.

Decomposition:
- Package system_led_seq_pkg holds:
  - register address constants (ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_STATUS=2, ADDR_TABLE_BASE=8);
  - CTRL and STATUS bit-position constants;
  - the FSM state enum (IDLE, ISSUE, HOLD).
- Sub-module system_led_seq_timer holds the loadable PERIOD_W down-counter, with inputs load and value and output expire.

Test Plan:
- Table = 01,02,04,08; LAST=3; PERIOD=4; EN=1 -> PIO out_port steps 01->02->04->08->01. Accepted writes are 5 clocks apart; DONE sets at the first wrap.
- ONESHOT=1, LAST=1, table 0xAA,0x55 -> exactly two master writes; out_port ends at 0x55; EN reads 0; BUSY=0; DONE=1.
- m_waitrequest held high for 3 cycles during ISSUE -> m_writedata, m_chipselect and m_write_n stable; the counter starts only after acceptance.
- PERIOD=0 -> behaves as PERIOD=1 (2-clock steps). LAST=15 with NUM_PATTERNS=8 -> wraps after index 7.
- EN cleared during HOLD at IDX=2 -> no further master writes; out_port holds table[2]; re-enable restarts at IDX 0.
- reset_n pulsed low mid-ISSUE -> m_write_n=1 and m_chipselect=0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/system_led_seq_pkg.sv
// Shared constants and FSM state type for the LED sequencer and its timer.
package system_led_seq_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_PERIOD     = 4'd1;
    localparam logic [3:0] ADDR_STATUS     = 4'd2;
    localparam logic [3:0] ADDR_TABLE_BASE = 4'd8;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_IE_BIT      = 2;
    localparam int CTRL_LAST_LSB    = 4;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_IDX_LSB  = 4;
    localparam int STATUS_DONE_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/system_led_seq_timer.sv
// Loadable step-period down-counter; expire flags the last cycle of a step.
module system_led_seq_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PERIOD_W-1:0] value,
    output logic                expire
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    // A zero period is stretched to one so every step still lasts two clocks.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (value == '0) ? PERIOD_W'(1) : value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/system_led_sequencer.sv
// Avalon-MM LED pattern sequencer: slave register file plus a master that writes the PIO.
// Define LED_SEQ_IRQ_EN to add the CTRL.IE bit and the registered irq output.
module system_led_sequencer
    import system_led_seq_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int DATA_W       = 8,
    parameter int PERIOD_W     = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [5:0] NUM_PAT_6 = 6'(NUM_PATTERNS);

    seq_state_e          state_q, state_d;
    logic                en_q, en_d, oneshot_q, oneshot_d, done_q, done_d;
    logic [3:0]          last_q, last_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [IDX_W-1:0]    idx_q, idx_d, last_eff, tbl_idx;
    logic [DATA_W-1:0]   pat_q [NUM_PATTERNS];
    logic [DATA_W-1:0]   pat_d [NUM_PATTERNS];
    logic                m_cs_q, m_cs_d, m_wr_n_q, m_wr_n_d;
    logic [31:0]         m_wd_q, m_wd_d;
    logic                wr, tbl_hit, expire, load, ie;
    logic [4:0]          tbl_off;
    logic                unused_wd;

    assign wr        = chipselect && !write_n;
    assign tbl_off   = {1'b0, address} - {1'b0, ADDR_TABLE_BASE};
    assign tbl_hit   = (address >= ADDR_TABLE_BASE) && ({1'b0, tbl_off} < NUM_PAT_6);
    assign tbl_idx   = tbl_off[IDX_W-1:0];
    assign last_eff  = ({1'b0, last_q} > 5'(NUM_PATTERNS - 1)) ? IDX_MAX : last_q[IDX_W-1:0];
    assign load      = (state_q == ISSUE) && !m_waitrequest;
    assign unused_wd = ^writedata;

    system_led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .load   (load),
        .value  (period_q),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        last_d    = last_q;
        period_d  = period_q;
        done_d    = done_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        m_cs_d    = m_cs_q;
        m_wr_n_d  = m_wr_n_q;
        m_wd_d    = m_wd_q;

        if (wr) begin
            case (address)
                ADDR_CTRL: begin
                    en_d      = writedata[CTRL_EN_BIT];
                    oneshot_d = writedata[CTRL_ONESHOT_BIT];
                    last_d    = writedata[CTRL_LAST_LSB +: 4];
                end
                ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
                ADDR_STATUS: if (writedata[STATUS_DONE_BIT]) done_d = 1'b0;
                default:     if (tbl_hit) pat_d[tbl_idx] = writedata[DATA_W-1:0];
            endcase
        end

        // Sequencing is evaluated after the slave write so a hardware DONE set or
        // EN clear overrides software in the same cycle.
        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                if (!m_waitrequest) begin
                    m_cs_d   = 1'b0;
                    m_wr_n_d = 1'b1;
                    state_d  = en_q ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (expire) begin
                    if (idx_q >= last_eff) begin
                        done_d = 1'b1;
                        if (oneshot_q) begin
                            en_d    = 1'b0;
                            state_d = IDLE;
                        end else begin
                            idx_d   = '0;
                            state_d = ISSUE;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Master write is presented from the first ISSUE cycle, so it is latched on entry.
        if (state_d == ISSUE && state_q != ISSUE) begin
            m_cs_d   = 1'b1;
            m_wr_n_d = 1'b0;
            m_wd_d   = 32'(pat_q[idx_d]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            last_q    <= '0;
            period_q  <= '0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            m_cs_q    <= 1'b0;
            m_wr_n_q  <= 1'b1;
            m_wd_q    <= '0;
            for (int i = 0; i < NUM_PATTERNS; i++) pat_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            last_q    <= last_d;
            period_q  <= period_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            m_cs_q    <= m_cs_d;
            m_wr_n_q  <= m_wr_n_d;
            m_wd_q    <= m_wd_d;
            pat_q     <= pat_d;
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic ie_q, ie_d, irq_q;

    always_comb begin
        ie_d = ie_q;
        if (wr && address == ADDR_CTRL) ie_d = writedata[CTRL_IE_BIT];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= done_d & ie_d;
        end
    end

    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]           = en_q;
                readdata[CTRL_ONESHOT_BIT]      = oneshot_q;
                readdata[CTRL_IE_BIT]           = ie;
                readdata[CTRL_LAST_LSB +: 4]    = last_q;
            end
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT]         = (state_q != IDLE);
                readdata[STATUS_IDX_LSB +: IDX_W] = idx_q;
                readdata[STATUS_DONE_BIT]         = done_q;
            end
            default: if (tbl_hit) readdata[DATA_W-1:0] = pat_q[tbl_idx];
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wr_n_q;
    assign m_writedata  = m_wd_q;

endmodule

// File: tb/tb_system_led_sequencer.sv
// Bench for system_led_sequencer: PIO model, randomized pattern runs, protocol corner cases.
module tb_system_led_sequencer;
    import system_led_seq_pkg::*;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  out_port;
    logic [7:0]  obs_data_q[$];
    int          obs_cyc_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  tbl [NP];

    system_led_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PIO out_port register plus monitor of accepted master writes
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= 8'h00;
        end else if (m_chipselect && !m_write_n && !m_waitrequest) begin
            out_port <= m_writedata[7:0];
            obs_data_q.push_back(m_writedata[7:0]);
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NP; i++) bus_write(4'(8 + i), 32'(tbl[i]));
    endtask

    task automatic clear_obs();
        obs_data_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (obs_data_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_data_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait: saw %0d master writes, required %0d", name, obs_data_q.size(), n);
        end
    endtask

    task automatic wait_cs(input string name);
        int k = 0;
        while (m_chipselect !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL %s_cs: m_chipselect=%b, required 1", name, m_chipselect);
        end
    endtask

    task automatic stop_seq();
        logic [31:0] rd;
        int k = 0;
        bus_write(ADDR_CTRL, 32'h0);
        bus_read(ADDR_STATUS, rd);
        while (rd[0] && k < 50) begin
            bus_read(ADDR_STATUS, rd);
            k++;
        end
        checks++;
        if (rd[0] !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: BUSY=%b, required 0", rd[0]);
        end
        bus_write(ADDR_STATUS, 32'h100);
        clear_obs();
    endtask

    // Expected writes: the k-th accepted write carries table[k mod (LAST'+1)],
    // LAST' = min(LAST, NP-1), spaced max(PERIOD,1)+1 clocks apart.
    task automatic run_loop(input int last, input int period, input int nw, input string name);
        int le, step;
        logic [31:0] rd;
        le   = (last > NP - 1) ? NP - 1 : last;
        step = ((period == 0) ? 1 : period) + 1;
        exp_q.delete();
        for (int k = 0; k < nw; k++) exp_q.push_back(tbl[k % (le + 1)]);
        clear_obs();
        bus_write(ADDR_PERIOD, 32'(period));
        bus_write(ADDR_CTRL, 32'((last << 4) | 1));
        if (period >= 3) begin
            wait_writes(le + 1, (le + 1) * (step + 2) + 20, name);
            bus_read(ADDR_STATUS, rd);
            checks++;
            if (rd[8] !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_early: DONE=%b, required 0", name, rd[8]);
            end
        end
        wait_writes(nw, nw * (step + 2) + 20, name);
        for (int k = 0; k < nw && k < obs_data_q.size(); k++) begin
            checks++;
            if (obs_data_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %02h, expected %02h", name, k, obs_data_q[k], exp_q[k]);
            end
            if (k > 0) begin
                checks++;
                if (obs_cyc_q[k] - obs_cyc_q[k-1] != step) begin
                    errors++;
                    $display("FAIL %s_gap[%0d]: got %0d clocks, expected %0d", name, k,
                             obs_cyc_q[k] - obs_cyc_q[k-1], step);
                end
            end
        end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[8] !== 1'b1 || rd[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s_status: DONE=%b BUSY=%b, expected DONE=1 BUSY=1", name, rd[8], rd[0]);
        end
        stop_seq();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        checks++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'h0 || m_address !== 2'b00) begin
            errors++;
            $display("FAIL reset_master: cs=%b wr_n=%b wd=%h addr=%b, expected 0 1 0 0",
                     m_chipselect, m_write_n, m_writedata, m_address);
        end
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h, expected 0", a, rd);
            end
        end
    endtask

    task automatic test_ctrl_regs();
        logic [31:0] rd, exp_ctrl;
        bus_write(ADDR_CTRL, 32'h76);
`ifdef LED_SEQ_IRQ_EN
        exp_ctrl = 32'h76;
`else
        exp_ctrl = 32'h72;
`endif
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd !== exp_ctrl) begin
            errors++;
            $display("FAIL ctrl_rw: got %h, expected %h", rd, exp_ctrl);
        end
        bus_write(ADDR_PERIOD, 32'hABCDEF12);
        bus_read(ADDR_PERIOD, rd);
        checks++;
        if (rd !== 32'h00CDEF12) begin
            errors++;
            $display("FAIL period_rw: got %h, expected 00cdef12", rd);
        end
        bus_write(4'd3, 32'hFFFF_FFFF);
        bus_read(4'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped: got %h, expected 0", rd);
        end
        bus_write(4'd15, 32'h1234_56C3);
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0000_00C3) begin
            errors++;
            $display("FAIL table_rw: got %h, expected 000000c3", rd);
        end
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_pattern_loop();
        for (int i = 0; i < NP; i++) tbl[i] = 8'($urandom_range(0, 255));
        tbl[0] = 8'h01; tbl[1] = 8'h02; tbl[2] = 8'h04; tbl[3] = 8'h08;
        load_table();
        run_loop(3, 4, 6, "loop_basic");
    endtask

    task automatic test_random_loop();
        for (int it = 0; it < 4; it++) begin
            int last, period;
            for (int i = 0; i < NP; i++) tbl[i] = 8'($urandom_range(0, 255));
            load_table();
            last   = (it == 0) ? 15 : $urandom_range(0, 15);
            period = (it == 0) ? 0 : $urandom_range(0, 6);
            run_loop(last, period, ((last > NP - 1) ? NP - 1 : last) + 2 + $urandom_range(0, 3), "loop_rand");
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        int k = 0;
        for (int i = 0; i < NP; i++) tbl[i] = 8'($urandom_range(0, 255));
        tbl[0] = 8'hAA; tbl[1] = 8'h55;
        load_table();
        clear_obs();
        bus_write(ADDR_PERIOD, 32'($urandom_range(1, 5)));
        bus_write(ADDR_CTRL, 32'h13);
        wait_writes(2, 40, "oneshot");
        bus_read(ADDR_STATUS, rd);
        while (rd[0] && k < 40) begin
            bus_read(ADDR_STATUS, rd);
            k++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (obs_data_q.size() != 2) begin
            errors++;
            $display("FAIL oneshot_count: got %0d writes, expected 2", obs_data_q.size());
        end
        checks++;
        if (out_port !== 8'h55) begin
            errors++;
            $display("FAIL oneshot_led: got %02h, expected 55", out_port);
        end
        bus_read(ADDR_CTRL, rd);
        checks++;
        if (rd[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_en: got %b, expected 0", rd[0]);
        end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[0] !== 1'b0 || rd[8] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_status: BUSY=%b DONE=%b, expected BUSY=0 DONE=1", rd[0], rd[8]);
        end
        stop_seq();
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[8] !== 1'b0) begin
            errors++;
            $display("FAIL done_clear: DONE=%b, expected 0", rd[8]);
        end
    endtask

    task automatic test_waitrequest();
        for (int i = 0; i < NP; i++) tbl[i] = 8'($urandom_range(0, 255));
        load_table();
        clear_obs();
        @(negedge clk);
        m_waitrequest = 1'b1;
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_CTRL, 32'h31);
        wait_cs("waitreq");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'(tbl[0]) ||
                obs_data_q.size() != 0) begin
                errors++;
                $display("FAIL waitreq_hold[%0d]: cs=%b wr_n=%b wd=%h, expected 1 0 %h", i,
                         m_chipselect, m_write_n, m_writedata, 32'(tbl[0]));
            end
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        wait_writes(2, 40, "waitreq");
        if (obs_data_q.size() >= 2) begin
            checks++;
            if (obs_data_q[0] !== tbl[0] || obs_data_q[1] !== tbl[1]) begin
                errors++;
                $display("FAIL waitreq_data: got %02h %02h, expected %02h %02h",
                         obs_data_q[0], obs_data_q[1], tbl[0], tbl[1]);
            end
            checks++;
            if (obs_cyc_q[1] - obs_cyc_q[0] != 4) begin
                errors++;
                $display("FAIL waitreq_gap: got %0d clocks, expected 4", obs_cyc_q[1] - obs_cyc_q[0]);
            end
        end
        stop_seq();
    endtask

    task automatic test_en_clear_hold();
        logic [31:0] rd;
        for (int i = 0; i < NP; i++) tbl[i] = 8'($urandom_range(0, 255));
        load_table();
        clear_obs();
        bus_write(ADDR_PERIOD, 32'd10);
        bus_write(ADDR_CTRL, 32'h31);
        wait_writes(3, 60, "en_clear");
        bus_write(ADDR_CTRL, 32'h30);
        repeat (30) @(negedge clk);
        checks++;
        if (obs_data_q.size() != 3) begin
            errors++;
            $display("FAIL en_clear_count: got %0d writes, expected 3", obs_data_q.size());
        end
        checks++;
        if (out_port !== tbl[2]) begin
            errors++;
            $display("FAIL en_clear_led: got %02h, expected %02h", out_port, tbl[2]);
        end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_clear_busy: got %b, expected 0", rd[0]);
        end
        clear_obs();
        bus_write(ADDR_CTRL, 32'h31);
        wait_writes(1, 20, "restart");
        if (obs_data_q.size() >= 1) begin
            checks++;
            if (obs_data_q[0] !== tbl[0]) begin
                errors++;
                $display("FAIL restart_data: got %02h, expected %02h", obs_data_q[0], tbl[0]);
            end
        end
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd[7:4] !== 4'd0) begin
            errors++;
            $display("FAIL restart_idx: got %0d, expected 0", rd[7:4]);
        end
        stop_seq();
    endtask

    task automatic test_reset_mid_issue();
        logic [31:0] rd;
        @(negedge clk);
        m_waitrequest = 1'b1;
        bus_write(ADDR_PERIOD, 32'd5);
        bus_write(ADDR_CTRL, 32'h33);
        wait_cs("reset_mid");
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: cs=%b wr_n=%b, expected 0 1", m_chipselect, m_write_n);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_waitrequest = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL post_reset_reg[%0d]: got %h, expected 0", a, rd);
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ctrl_regs();
        test_pattern_loop();
        test_random_loop();
        test_oneshot();
        test_waitrequest();
        test_en_clear_hold();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
